mem_req_master: RTL

- Initiator that drives the team's byte-addressed 64-bit data memory on behalf of the core's load/store stage.
- Accepts one load or store request at a time, with byte, half, word or dword size.
- Issues single-cycle rd_en/wr_en pulses to the memory and waits for the memory's rd_done/wr_done.
- Sub-dword stores are done as read-modify-write. Returns sign- or zero-extended load data, or an error code.

---
 rtl/mem_req_master.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/mem_req_master.sv
// Load/store initiator for the 64-bit byte-addressed data memory; sub-dword stores use read-modify-write.
// Latency: 3 cycles for loads and dword stores, 5 for sub-dword stores, 1 for range errors; one request at a time.
module mem_req_master #(
    parameter int DATA_W    = 64,
    parameter int MEM_DEPTH = 1024,
    parameter int TIMEOUT   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [DATA_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_data,
    output logic [1:0]        resp_err,
    output logic              mem_rd_en,
    output logic              mem_wr_en,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    input  logic [DATA_W-1:0] mem_rd_data,
    input  logic              mem_rd_done,
    input  logic              mem_wr_done
);
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [1:0] ERR_OK      = 2'd0;
    localparam logic [1:0] ERR_RANGE   = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;

    typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, RESP} state_t;

    state_t            state;
    logic              lat_we;
    logic [1:0]        lat_size;
    logic              lat_signed;
    logic [DATA_W-1:0] lat_wdata;
    logic [CNT_W-1:0]  cnt;

    logic [DATA_W:0]   end_addr;
    logic              range_err;
    logic [DATA_W-1:0] lane_mask;
    logic [DATA_W-1:0] load_data;
    logic [DATA_W-1:0] merge_data;
    logic              sign_bit;

    assign req_ready = (state == IDLE);

    // One extra bit so addresses near the top of the 64-bit space cannot wrap past the check.
    assign end_addr  = {1'b0, req_addr} + (DATA_W+1)'(8);
    assign range_err = end_addr > (DATA_W+1)'(MEM_DEPTH);

    always_comb begin
        lane_mask = '1;
        sign_bit  = mem_rd_data[DATA_W-1];
        case (lat_size)
            2'd0: begin lane_mask = DATA_W'(64'hFF);       sign_bit = mem_rd_data[7];  end
            2'd1: begin lane_mask = DATA_W'(64'hFFFF);     sign_bit = mem_rd_data[15]; end
            2'd2: begin lane_mask = DATA_W'(64'hFFFF_FFFF); sign_bit = mem_rd_data[31]; end
            default: ;
        endcase
        load_data  = (mem_rd_data & lane_mask) | ((lat_signed && sign_bit) ? ~lane_mask : '0);
        merge_data = (lat_wdata & lane_mask) | (mem_rd_data & ~lane_mask);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            lat_we      <= 1'b0;
            lat_size    <= 2'd0;
            lat_signed  <= 1'b0;
            lat_wdata   <= '0;
            cnt         <= '0;
            resp_valid  <= 1'b0;
            resp_data   <= '0;
            resp_err    <= ERR_OK;
            mem_rd_en   <= 1'b0;
            mem_wr_en   <= 1'b0;
            mem_addr    <= '0;
            mem_wr_data <= '0;
        end else begin
            mem_rd_en  <= 1'b0;
            mem_wr_en  <= 1'b0;
            resp_valid <= 1'b0;
            case (state)
                IDLE: if (req_valid) begin
                    lat_we     <= req_we;
                    lat_size   <= req_size;
                    lat_signed <= req_signed;
                    lat_wdata  <= req_wdata;
                    mem_addr   <= req_addr;
                    cnt        <= '0;
                    if (range_err) begin
                        resp_valid <= 1'b1;
                        resp_data  <= '0;
                        resp_err   <= ERR_RANGE;
                        state      <= RESP;
                    end else if (req_we && req_size == 2'd3) begin
                        mem_wr_en   <= 1'b1;
                        mem_wr_data <= req_wdata;
                        state       <= WR_WAIT;
                    end else begin
                        mem_rd_en <= 1'b1;
                        state     <= RD_WAIT;
                    end
                end
                RD_WAIT: if (mem_rd_done) begin
                    if (lat_we) begin
                        mem_wr_en   <= 1'b1;
                        mem_wr_data <= merge_data;
                        cnt         <= '0;
                        state       <= WR_WAIT;
                    end else begin
                        resp_valid <= 1'b1;
                        resp_data  <= load_data;
                        resp_err   <= ERR_OK;
                        state      <= RESP;
                    end
                end else if (cnt == CNT_LAST) begin
                    resp_valid <= 1'b1;
                    resp_data  <= '0;
                    resp_err   <= ERR_TIMEOUT;
                    state      <= RESP;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                WR_WAIT: if (mem_wr_done) begin
                    resp_valid <= 1'b1;
                    resp_data  <= '0;
                    resp_err   <= ERR_OK;
                    state      <= RESP;
                end else if (cnt == CNT_LAST) begin
                    resp_valid <= 1'b1;
                    resp_data  <= '0;
                    resp_err   <= ERR_TIMEOUT;
                    state      <= RESP;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
